// File: rtl/cpu_sram_arbiter_if.sv
// Bundle of the fetch, load/store and shared SRAM-port signals around the arbiter.
interface cpu_sram_arbiter_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  // Fetch port
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic          inst_addr_ok;
  logic          inst_data_ok;
  logic [DW-1:0] inst_rdata;

  // Load/store port
  logic          data_req;
  logic          data_wr;
  logic [SW-1:0] data_wstrb;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_addr_ok;
  logic          data_data_ok;
  logic [DW-1:0] data_rdata;

  // Shared memory port
  logic          mem_req;
  logic          mem_wr;
  logic [SW-1:0] mem_wstrb;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_addr_ok;
  logic          mem_data_ok;
  logic [DW-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  // CPU and memory side
  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );
endinterface

// File: rtl/cpu_sram_arbiter.sv
// Two-port (fetch / load-store) arbiter onto one SRAM-like port, one transaction in flight,
// data port preferred with a starvation guard for fetches.
module cpu_sram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                reset,
  cpu_sram_arbiter_if.slave  bus_if
);
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned SW    = 4;
  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT} state_e;
  typedef enum logic {OWN_INST, OWN_DATA} owner_e;

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  logic             wr_q, wr_d;
  logic [SW-1:0]    wstrb_q, wstrb_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             starved;
  logic             grant_inst;
  logic             grant_data;

  // State, latched request and starvation counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_INST;
      wr_q     <= 1'b0;
      wstrb_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      wr_q     <= wr_d;
      wstrb_q  <= wstrb_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      starve_q <= starve_d;
    end
  end

  // Grant, next state and handshakes; everything is held low while reset is high
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    wr_d       = wr_q;
    wstrb_d    = wstrb_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    starve_d   = starve_q;
    starved    = (starve_q == CNT_W'(STARVE_LIMIT));
    grant_inst = 1'b0;
    grant_data = 1'b0;
    bus_if.inst_addr_ok = 1'b0;
    bus_if.data_addr_ok = 1'b0;
    bus_if.inst_data_ok = 1'b0;
    bus_if.data_data_ok = 1'b0;
    bus_if.mem_req      = 1'b0;

    if (!reset) begin
      unique case (state_q)
        S_IDLE: begin
          grant_inst = bus_if.inst_req && (!bus_if.data_req || starved);
          grant_data = bus_if.data_req && !grant_inst;
          bus_if.inst_addr_ok = grant_inst;
          bus_if.data_addr_ok = grant_data;
          if (grant_data) begin
            owner_d = OWN_DATA;
            wr_d    = bus_if.data_wr;
            wstrb_d = bus_if.data_wstrb;
            addr_d  = bus_if.data_addr;
            wdata_d = bus_if.data_wdata;
            state_d = S_ADDR;
          end else if (grant_inst) begin
            owner_d = OWN_INST;
            wr_d    = 1'b0;
            wstrb_d = '0;
            addr_d  = bus_if.inst_addr;
            wdata_d = '0;
            state_d = S_ADDR;
          end
          // Count data wins only while a fetch is being held off
          if (grant_inst || !bus_if.inst_req) begin
            starve_d = '0;
          end else if (grant_data && !starved) begin
            starve_d = starve_q + CNT_W'(1);
          end
        end
        S_ADDR: begin
          bus_if.mem_req = 1'b1;
          if (bus_if.mem_addr_ok) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (bus_if.mem_data_ok) begin
            bus_if.inst_data_ok = (owner_q == OWN_INST);
            bus_if.data_data_ok = (owner_q == OWN_DATA);
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Request fields come straight from the latch so they stay stable while mem_req waits
  assign bus_if.mem_wr     = wr_q;
  assign bus_if.mem_wstrb  = wstrb_q;
  assign bus_if.mem_addr   = addr_q;
  assign bus_if.mem_wdata  = wdata_q;
  assign bus_if.inst_rdata = bus_if.mem_rdata;
  assign bus_if.data_rdata = bus_if.mem_rdata;
endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Bench for cpu_sram_arbiter: directed vector table, multi-cycle corner sequences and a
// randomized run against a transaction-level reference model.
module tb_cpu_sram_arbiter;
  localparam int unsigned LIMIT       = 4;
  localparam int unsigned RAND_CYCLES = 3000;
  localparam logic [31:0] IA = 32'h1c00_0000;
  localparam logic [31:0] DA = 32'h1c00_1000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_sram_arbiter_if bus_if();

  cpu_sram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus_if)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        rst, ir, dr, dw, maok, mdok;
    logic [31:0] rdata;
    logic        e_iaok, e_daok, e_mreq, e_mwr, e_idok, e_ddok;
    logic [31:0] e_maddr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic ir, logic dr, logic dw, logic maok, logic mdok,
                              logic [31:0] rdata, logic e_iaok, logic e_daok, logic e_mreq,
                              logic e_mwr, logic e_idok, logic e_ddok, logic [31:0] e_maddr);
    vec_t v;
    v.rst = rst; v.ir = ir; v.dr = dr; v.dw = dw; v.maok = maok; v.mdok = mdok; v.rdata = rdata;
    v.e_iaok = e_iaok; v.e_daok = e_daok; v.e_mreq = e_mreq; v.e_mwr = e_mwr;
    v.e_idok = e_idok; v.e_ddok = e_ddok; v.e_maddr = e_maddr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic ir, input logic dr, input logic dw,
                       input logic maok, input logic mdok, input logic [31:0] rdata);
    reset              = rst;
    bus_if.inst_req    = ir;
    bus_if.data_req    = dr;
    bus_if.data_wr     = dw;
    bus_if.mem_addr_ok = maok;
    bus_if.mem_data_ok = mdok;
    bus_if.mem_rdata   = rdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_default_fields();
    bus_if.inst_addr  = IA;
    bus_if.data_addr  = DA;
    bus_if.data_wstrb = 4'hF;
    bus_if.data_wdata = 32'h1234_5678;
  endtask

  // Reference model state: one pending transaction, whether memory took its address, and the
  // number of back-to-back data wins while a fetch waited
  bit          m_pending, m_issued, m_owner_data, m_wr;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;
  int          m_streak;

  initial begin
    logic ir, dr, dw, maok, mdok, rst;
    logic [31:0] rdata;
    bit e_iaok, e_daok, e_mreq, e_idok, e_ddok;
    bit exp_data;

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    set_default_fields();
    @(posedge clk);
    #1;

    // Directed vectors: fetch, stray responses, contention, reset in WAIT and ADDR
    vecs.push_back(mk(1,1,1,0,0,1,32'h0,        0,0,0,0,0,0,32'h0));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,        0,0,0,0,0,0,32'h0));
    vecs.push_back(mk(0,1,0,0,0,0,32'h0,        1,0,0,0,0,0,32'h0));
    vecs.push_back(mk(0,0,0,0,1,0,32'h0,        0,0,1,0,0,0,IA));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,        0,0,0,0,0,0,32'h0));
    vecs.push_back(mk(0,0,0,0,0,1,32'h0280_0000,0,0,0,0,1,0,32'h0));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,        0,0,0,0,0,0,32'h0));
    vecs.push_back(mk(0,0,0,0,0,1,32'h55,       0,0,0,0,0,0,32'h0));
    vecs.push_back(mk(0,1,1,1,0,0,32'h0,        0,1,0,0,0,0,32'h0));
    vecs.push_back(mk(0,1,0,1,0,1,32'h66,       0,0,1,1,0,0,DA));
    vecs.push_back(mk(0,1,0,0,1,0,32'h0,        0,0,1,1,0,0,DA));
    vecs.push_back(mk(0,1,0,0,0,0,32'h0,        0,0,0,0,0,0,32'h0));
    vecs.push_back(mk(0,1,0,0,0,1,32'h77,       0,0,0,0,0,1,32'h0));
    vecs.push_back(mk(0,1,0,0,0,0,32'h0,        1,0,0,0,0,0,32'h0));
    vecs.push_back(mk(0,0,0,0,1,0,32'h0,        0,0,1,0,0,0,IA));
    vecs.push_back(mk(1,0,0,0,0,0,32'h0,        0,0,0,0,0,0,32'h0));
    vecs.push_back(mk(0,0,0,0,0,1,32'h88,       0,0,0,0,0,0,32'h0));
    vecs.push_back(mk(0,0,1,0,0,0,32'h0,        0,1,0,0,0,0,32'h0));
    vecs.push_back(mk(0,0,0,0,1,0,32'h0,        0,0,1,0,0,0,DA));
    vecs.push_back(mk(0,0,0,0,0,1,32'hdead_beef,0,0,0,0,0,1,32'h0));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,        0,0,0,0,0,0,32'h0));
    vecs.push_back(mk(0,0,1,0,0,0,32'h0,        0,1,0,0,0,0,32'h0));
    vecs.push_back(mk(1,0,0,0,0,0,32'h0,        0,0,0,0,0,0,32'h0));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,        0,0,0,0,0,0,32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].ir, vecs[i].dr, vecs[i].dw, vecs[i].maok, vecs[i].mdok,
            vecs[i].rdata);
      @(negedge clk);
      check($sformatf("vec%0d inst_addr_ok", i), bus_if.inst_addr_ok, vecs[i].e_iaok);
      check($sformatf("vec%0d data_addr_ok", i), bus_if.data_addr_ok, vecs[i].e_daok);
      check($sformatf("vec%0d mem_req", i), bus_if.mem_req, vecs[i].e_mreq);
      check($sformatf("vec%0d inst_data_ok", i), bus_if.inst_data_ok, vecs[i].e_idok);
      check($sformatf("vec%0d data_data_ok", i), bus_if.data_data_ok, vecs[i].e_ddok);
      check($sformatf("vec%0d inst_rdata", i), bus_if.inst_rdata, vecs[i].rdata);
      check($sformatf("vec%0d data_rdata", i), bus_if.data_rdata, vecs[i].rdata);
      if (vecs[i].e_mreq) begin
        check($sformatf("vec%0d mem_wr", i), bus_if.mem_wr, vecs[i].e_mwr);
        check($sformatf("vec%0d mem_addr", i), bus_if.mem_addr, vecs[i].e_maddr);
        if (vecs[i].e_mwr) begin
          check($sformatf("vec%0d mem_wdata", i), bus_if.mem_wdata, 32'h1234_5678);
          check($sformatf("vec%0d mem_wstrb", i), bus_if.mem_wstrb, 32'hF);
        end
      end
      next_cycle();
    end

    // Starvation: both ports hold their requests; LIMIT data grants, one fetch, then data again
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    for (int t = 0; t < int'(LIMIT) + 2; t++) begin
      exp_data = (t != int'(LIMIT));
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      check($sformatf("starve%0d data_addr_ok", t), bus_if.data_addr_ok, exp_data);
      check($sformatf("starve%0d inst_addr_ok", t), bus_if.inst_addr_ok, !exp_data);
      next_cycle();
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      next_cycle();
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'hc0de_0000 + 32'(t));
      @(negedge clk);
      check($sformatf("starve%0d data_data_ok", t), bus_if.data_data_ok, exp_data);
      check($sformatf("starve%0d inst_data_ok", t), bus_if.inst_data_ok, !exp_data);
      next_cycle();
    end

    // Slow slave: request fields frozen and no grants while mem_addr_ok stays low
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    bus_if.data_addr  = 32'h1c00_2000;
    bus_if.data_wdata = 32'ha5a5_a5a5;
    bus_if.data_wstrb = 4'h3;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("slow grant data_addr_ok", bus_if.data_addr_ok, 1'b1);
    next_cycle();
    bus_if.data_addr  = 32'h0;
    bus_if.data_wdata = 32'h0;
    bus_if.data_wstrb = 4'h0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      check($sformatf("slow%0d mem_req", c), bus_if.mem_req, 1'b1);
      check($sformatf("slow%0d mem_addr", c), bus_if.mem_addr, 32'h1c00_2000);
      check($sformatf("slow%0d mem_wdata", c), bus_if.mem_wdata, 32'ha5a5_a5a5);
      check($sformatf("slow%0d mem_wstrb", c), bus_if.mem_wstrb, 32'h3);
      check($sformatf("slow%0d addr_ok", c), {bus_if.inst_addr_ok, bus_if.data_addr_ok}, 32'h0);
      next_cycle();
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("slow accept mem_req", bus_if.mem_req, 1'b1);
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    check("slow done data_data_ok", bus_if.data_data_ok, 1'b1);
    check("slow done inst_addr_ok", bus_if.inst_addr_ok, 1'b0);
    next_cycle();

    // Randomized run against the reference model
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    m_pending = 0; m_issued = 0; m_streak = 0; m_owner_data = 0;
    m_wr = 0; m_wstrb = '0; m_addr = '0; m_wdata = '0;
    for (int n = 0; n < int'(RAND_CYCLES); n++) begin
      rst   = ($urandom_range(0, 49) == 0);
      ir    = $urandom_range(0, 1) == 1;
      dr    = $urandom_range(0, 1) == 1;
      dw    = $urandom_range(0, 1) == 1;
      maok  = $urandom_range(0, 1) == 1;
      mdok  = $urandom_range(0, 4) < 2;
      rdata = $urandom;
      bus_if.inst_addr  = {$urandom} & 32'hffff_fffc;
      bus_if.data_addr  = {$urandom} & 32'hffff_fffc;
      bus_if.data_wstrb = 4'($urandom);
      bus_if.data_wdata = $urandom;
      drive(rst, ir, dr, dw, maok, mdok, rdata);

      e_iaok = 0; e_daok = 0; e_mreq = 0; e_idok = 0; e_ddok = 0;
      if (rst) begin
      end else if (!m_pending) begin
        if (dr && !(ir && m_streak >= int'(LIMIT))) e_daok = 1;
        else if (ir) e_iaok = 1;
      end else if (!m_issued) begin
        e_mreq = 1;
      end else if (mdok) begin
        if (m_owner_data) e_ddok = 1;
        else e_idok = 1;
      end

      @(negedge clk);
      check("rand inst_addr_ok", bus_if.inst_addr_ok, e_iaok);
      check("rand data_addr_ok", bus_if.data_addr_ok, e_daok);
      check("rand mem_req", bus_if.mem_req, e_mreq);
      check("rand inst_data_ok", bus_if.inst_data_ok, e_idok);
      check("rand data_data_ok", bus_if.data_data_ok, e_ddok);
      check("rand inst_rdata", bus_if.inst_rdata, rdata);
      check("rand data_rdata", bus_if.data_rdata, rdata);
      if (e_mreq) begin
        check("rand mem_addr", bus_if.mem_addr, m_addr);
        check("rand mem_wr", bus_if.mem_wr, m_wr);
        check("rand mem_wstrb", bus_if.mem_wstrb, m_wstrb);
        if (m_wr) check("rand mem_wdata", bus_if.mem_wdata, m_wdata);
      end

      if (rst) begin
        m_pending = 0; m_issued = 0; m_streak = 0;
      end else if (!m_pending) begin
        if (e_iaok || !ir) m_streak = 0;
        else if (e_daok) m_streak = (m_streak + 1 > int'(LIMIT)) ? int'(LIMIT) : m_streak + 1;
        if (e_daok) begin
          m_pending = 1; m_issued = 0; m_owner_data = 1;
          m_wr = dw; m_wstrb = bus_if.data_wstrb; m_addr = bus_if.data_addr;
          m_wdata = bus_if.data_wdata;
        end else if (e_iaok) begin
          m_pending = 1; m_issued = 0; m_owner_data = 0;
          m_wr = 0; m_wstrb = '0; m_addr = bus_if.inst_addr; m_wdata = '0;
        end
      end else if (!m_issued) begin
        if (maok) m_issued = 1;
      end else if (mdok) begin
        m_pending = 0;
      end
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cpu_sram_arbiter.md
CPU_SRAM_ARBITER -- requirements
Module: cpu_sram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive data-port grants allowed while an instruction request waits.
REQ-002 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  reset: synchronous, active-high.
REQ-004 SHALL have port inst_req  input  1  fetch-side read request.
REQ-005 SHALL have port inst_addr  input  32  fetch address; word aligned.
REQ-006 SHALL have port inst_addr_ok  output  1  fetch request accepted this cycle.
REQ-007 SHALL have port inst_data_ok  output  1  fetch read data valid this cycle.
REQ-008 SHALL have port inst_rdata  output  32  fetch read data.
REQ-009 SHALL have port data_req  input  1  load/store request.
REQ-010 SHALL have port data_wr  input  1  1 = write, 0 = read.
REQ-011 SHALL have port data_wstrb  input  4  write byte enables.
REQ-012 SHALL have port data_addr  input  32  load/store address.
REQ-013 SHALL have port data_wdata  input  32  store data.
REQ-014 SHALL have port data_addr_ok  output  1  data request accepted this cycle.
REQ-015 SHALL have port data_data_ok  output  1  read data valid, or write complete, this cycle.
REQ-016 SHALL have port data_rdata  output  32  load data.
REQ-017 SHALL have output ports mem_req (1), mem_wr (1), mem_wstrb (4), mem_addr (32) and mem_wdata (32): the shared memory-port request.
REQ-018 SHALL have input ports mem_addr_ok (1), mem_data_ok (1) and mem_rdata (32): the shared memory-port response.

Function
REQ-019 SHALL implement a three-state FSM (IDLE, ADDR, WAIT) with at most one outstanding memory transaction.
REQ-020 SHALL grant, in IDLE only, exactly one requester per cycle, combinationally: the data port wins unless the starvation rule applies.
REQ-021 SHALL assert the winner's addr_ok in the IDLE grant cycle and latch owner, wr, wstrb, addr and wdata; ADDR follows. For inst, wr=0 and wstrb=0.
REQ-022 SHALL drive mem_req=1 from the latched registers throughout ADDR; the mem_* request outputs stay constant until mem_addr_ok.
REQ-023 SHALL move ADDR->WAIT on mem_addr_ok=1; without it, SHALL stay in ADDR.
REQ-024 SHALL, in WAIT on mem_data_ok=1, pass through combinationally: owner's data_ok=1, owner's rdata=mem_rdata. Next state: IDLE.
REQ-025 SHALL ignore mem_data_ok outside WAIT; it SHALL not raise any data_ok.
REQ-026 SHALL keep addr_ok=0 for both ports in ADDR and WAIT; a new grant needs at least one IDLE cycle after data_ok.
REQ-027 SHALL increment a starvation counter on each data grant while inst_req=1, saturating at STARVE_LIMIT.
REQ-028 SHALL clear the starvation counter on any inst grant, or when inst_req=0 in IDLE.
REQ-029 SHALL grant inst over data when the counter equals STARVE_LIMIT and both ports request.
REQ-030 SHALL drive mem_req=0 in IDLE and WAIT; both data_ok=0 except in the REQ-024 case.
REQ-031 SHALL drive inst_rdata and data_rdata as mem_rdata at all times; qualified only by data_ok.

Reset
REQ-032 SHALL, on reset=1 in any state including mid-transaction, at the next edge: enter IDLE, clear the owner and starvation counter, and drop mem_req.
REQ-033 SHALL discard any in-flight response; no data_ok SHALL assert for a transaction issued before reset.
REQ-034 SHALL hold all addr_ok, data_ok and mem_req at 0 while reset=1.

Verification
REQ-035 Single fetch: inst_req=1, addr 0x1c000000, cycle 0; mem_addr_ok cycle 1; mem_data_ok cycle 3 with rdata 0x02800000 -> inst_addr_ok cycle 0; mem_req cycles 1 only; inst_data_ok=1, inst_rdata=0x02800000 at cycle 3.
REQ-036 Contention: inst_req and data_req (write, addr 0x1c001000, wstrb 0xF, wdata 0x12345678) together -> data granted first, mem_wr=1; inst_addr_ok only in the IDLE cycle after data_data_ok.
REQ-037 Starvation: data_req held high with inst_req high, STARVE_LIMIT=4 -> exactly 4 data grants, then inst grant, then the counter restarts.
REQ-038 Slow slave: mem_addr_ok held 0 for 5 cycles -> mem_addr and mem_wdata stable, mem_req=1 for all 5 cycles; no addr_ok to either port.
REQ-039 Reset in WAIT, then mem_data_ok the cycle after reset falls -> no data_ok on either port; IDLE grants normally afterwards.
REQ-040 Stray mem_data_ok in IDLE or ADDR -> no data_ok on either port; state unchanged.
